// File: rtl/ap_sram_pkg.sv
// Shared types for the 16-bit async SRAM access port: controller states and wait-counter width.
package ap_sram_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/ap_sram_16.sv
// Single-access controller for a 16-bit asynchronous SRAM; every strobe is registered.
// Optional byte lanes (iMEM_BE) when AP_SRAM_BYTE_LANES_EN is defined, otherwise both lanes enabled.
module ap_sram_16
  import ap_sram_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iMEM_EN,
  input  logic              iMEM_RW,
  input  logic [31:0]       iMEM_ADDR,
  input  logic [15:0]       iMEM_WDATA,
`ifdef AP_SRAM_BYTE_LANES_EN
  input  logic [1:0]        iMEM_BE,
`endif
  output logic [15:0]       oMEM_RDATA,
  output logic              oMEM_RDY,
  output logic [ADDR_W-1:0] oSRAM_A,
  output logic [15:0]       oSRAM_D,
  output logic              oSRAM_D_OE,
  input  logic [15:0]       iSRAM_D,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_LB_N,
  output logic              oSRAM_UB_N
);

  localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(RD_WAIT - 1);
  localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WR_WAIT - 1);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                rdy_q, rdy_d;
  logic                abort_q, abort_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                lb_n_q, lb_n_d;
  logic                ub_n_q, ub_n_d;
  logic                d_oe_q, d_oe_d;
  logic                access_d;
  logic                unused_addr_hi;
`ifdef AP_SRAM_BYTE_LANES_EN
  logic [1:0]          be_q, be_d;
`endif

  assign unused_addr_hi = ^iMEM_ADDR[31:ADDR_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    rdy_d   = 1'b0;
`ifdef AP_SRAM_BYTE_LANES_EN
    be_d    = be_q;
`endif

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (iMEM_EN) begin
          addr_d  = iMEM_ADDR[ADDR_W-1:0];
          wdata_d = iMEM_WDATA;
`ifdef AP_SRAM_BYTE_LANES_EN
          be_d    = iMEM_BE;
`endif
          if (iMEM_RW) begin
            state_d = WR_SETUP;
          end else begin
            state_d = RD;
            cnt_d   = RD_LOAD;
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          rdata_d = iSRAM_D;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HOLD: state_d = DONE;
      DONE: begin
        // An access abandoned mid-flight parks here silently until EN is seen low.
        if (!iMEM_EN) begin
          state_d = IDLE;
        end else begin
          rdy_d = !abort_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q inside {RD, WR_SETUP, WR_PULSE, WR_HOLD}) && !iMEM_EN) begin
      abort_d = 1'b1;
    end

    // Strobes are decoded from the next state so they line up with state_q.
    access_d = state_d inside {RD, WR_SETUP, WR_PULSE, WR_HOLD};
    ce_n_d   = !access_d;
    oe_n_d   = (state_d != RD);
    we_n_d   = (state_d != WR_PULSE);
    d_oe_d   = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
`ifdef AP_SRAM_BYTE_LANES_EN
    lb_n_d   = !(access_d && be_d[0]);
    ub_n_d   = !(access_d && be_d[1]);
`else
    lb_n_d   = !access_d;
    ub_n_d   = !access_d;
`endif
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      abort_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      d_oe_q  <= 1'b0;
`ifdef AP_SRAM_BYTE_LANES_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      abort_q <= abort_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      lb_n_q  <= lb_n_d;
      ub_n_q  <= ub_n_d;
      d_oe_q  <= d_oe_d;
`ifdef AP_SRAM_BYTE_LANES_EN
      be_q    <= be_d;
`endif
    end
  end

  assign oMEM_RDATA = rdata_q;
  assign oMEM_RDY   = rdy_q;
  assign oSRAM_A    = addr_q;
  assign oSRAM_D    = wdata_q;
  assign oSRAM_D_OE = d_oe_q;
  assign oSRAM_CE_N = ce_n_q;
  assign oSRAM_OE_N = oe_n_q;
  assign oSRAM_WE_N = we_n_q;
  assign oSRAM_LB_N = lb_n_q;
  assign oSRAM_UB_N = ub_n_q;

endmodule

// File: tb/tb_ap_sram_16.sv
// Directed bench for ap_sram_16 (default parameters); byte-lane case runs when AP_SRAM_BYTE_LANES_EN is defined.
module tb_ap_sram_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rdy;
  logic [17:0] sram_a;
  logic [15:0] sram_d_out;
  logic        sram_d_oe;
  logic [15:0] sram_d_in;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
`ifdef AP_SRAM_BYTE_LANES_EN
  logic [1:0]  mem_be;
`endif

  int checks   = 0;
  int failures = 0;

  int oe_low, we_low, doe_hi, lb_low, ub_low, conflict, rdy_first;
  logic hold_ok;

  always #5 clk = ~clk;

  ap_sram_16 dut (
    .iCLK       (clk),
    .iRESET     (rst),
    .iMEM_EN    (mem_en),
    .iMEM_RW    (mem_rw),
    .iMEM_ADDR  (mem_addr),
    .iMEM_WDATA (mem_wdata),
`ifdef AP_SRAM_BYTE_LANES_EN
    .iMEM_BE    (mem_be),
`endif
    .oMEM_RDATA (mem_rdata),
    .oMEM_RDY   (mem_rdy),
    .oSRAM_A    (sram_a),
    .oSRAM_D    (sram_d_out),
    .oSRAM_D_OE (sram_d_oe),
    .iSRAM_D    (sram_d_in),
    .oSRAM_CE_N (ce_n),
    .oSRAM_OE_N (oe_n),
    .oSRAM_WE_N (we_n),
    .oSRAM_LB_N (lb_n),
    .oSRAM_UB_N (ub_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges, tallying strobe activity; k=0 is the edge that samples EN.
  // Request fields are scrambled after acceptance to prove they were latched.
  task automatic observe(input int n);
    oe_low = 0; we_low = 0; doe_hi = 0; lb_low = 0; ub_low = 0;
    conflict = 0; rdy_first = -1;
    for (int k = 0; k < n; k++) begin
      tick();
      if (!oe_n) oe_low++;
      if (!we_n) we_low++;
      if (sram_d_oe) doe_hi++;
      if (!lb_n) lb_low++;
      if (!ub_n) ub_low++;
      if (!oe_n && sram_d_oe) conflict++;
      if (mem_rdy && rdy_first < 0) rdy_first = k;
      if (k == 0) begin
        mem_rw    = ~mem_rw;
        mem_addr  = ~mem_addr;
        mem_wdata = ~mem_wdata;
      end
    end
  endtask

  task automatic gap();
    mem_en = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_rw = 1'b0; mem_addr = '0; mem_wdata = '0;
    sram_d_in = '0;
`ifdef AP_SRAM_BYTE_LANES_EN
    mem_be = 2'b11;
`endif
    tick(); tick();
    check("rst_ce_n",  ce_n, 1);
    check("rst_oe_n",  oe_n, 1);
    check("rst_we_n",  we_n, 1);
    check("rst_lb_n",  lb_n, 1);
    check("rst_ub_n",  ub_n, 1);
    check("rst_d_oe",  sram_d_oe, 0);
    check("rst_rdy",   mem_rdy, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_a",     sram_a, 0);
    check("rst_d",     sram_d_out, 0);
    rst = 1'b0;
    tick();

    // Read 0x10, SRAM returns 0xBEEF.
    mem_en = 1'b1; mem_rw = 1'b0; mem_addr = 32'h0000_0010; sram_d_in = 16'hBEEF;
    observe(6);
    check("rd_oe_low",    oe_low, 2);
    check("rd_rdy_edge",  rdy_first, 3);
    check("rd_rdata",     mem_rdata, 16'hBEEF);
    check("rd_addr",      sram_a, 18'h00010);
    check("rd_doe",       doe_hi, 0);
    check("rd_lanes",     lb_low, 2);
    check("rd_conflict",  conflict, 0);
    gap();
    check("rd_exit_rdy",  mem_rdy, 0);
    check("rd_exit_ce_n", ce_n, 1);

    // Write 0x1234 to 0x3FFFF.
    mem_en = 1'b1; mem_rw = 1'b1; mem_addr = 32'h0003_FFFF; mem_wdata = 16'h1234;
    observe(7);
    check("wr_we_low",    we_low, 2);
    check("wr_doe",       doe_hi, 4);
    check("wr_rdy_edge",  rdy_first, 5);
    check("wr_data",      sram_d_out, 16'h1234);
    check("wr_addr",      sram_a, 18'h3FFFF);
    check("wr_lb_low",    lb_low, 4);
    check("wr_ub_low",    ub_low, 4);
    check("wr_oe_low",    oe_low, 0);
    check("wr_conflict",  conflict, 0);
    gap();

    // Upper address bits dropped; then EN held 10 cycles past RDY.
    mem_en = 1'b1; mem_rw = 1'b0; mem_addr = 32'hFFFC_0005; sram_d_in = 16'h5A5A;
    observe(5);
    check("trunc_addr",     sram_a, 18'h00005);
    check("trunc_rdy_edge", rdy_first, 3);
    check("trunc_rdata",    mem_rdata, 16'h5A5A);
    sram_d_in = 16'h0000;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_rdy !== 1'b1 || mem_rdata !== 16'h5A5A) hold_ok = 1'b0;
    end
    check("hold_stable", hold_ok, 1);
    gap();
    check("hold_exit_rdy",  mem_rdy, 0);
    check("hold_exit_ce_n", ce_n, 1);

    // Next request accepted, then abandoned early.
    mem_en = 1'b1; mem_rw = 1'b0; mem_addr = 32'h0000_0022; sram_d_in = 16'h0F0F;
    tick();
    check("next_oe_n", oe_n, 0);
    check("next_addr", sram_a, 18'h00022);
    mem_en = 1'b0;
    observe(5);
    check("abort_rdy",   rdy_first, -1);
    check("abort_rdata", mem_rdata, 16'h0F0F);
    check("abort_ce_n",  ce_n, 1);

    // Reset in WR_PULSE.
    mem_en = 1'b1; mem_rw = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = 16'hAAAA;
    tick(); tick();
    check("pulse_we_n", we_n, 0);
    rst = 1'b1;
    tick();
    check("wrst_we_n", we_n, 1);
    check("wrst_rdy",  mem_rdy, 0);
    check("wrst_ce_n", ce_n, 1);
    check("wrst_d_oe", sram_d_oe, 0);
    rst = 1'b0; mem_en = 1'b0;
    tick();

`ifdef AP_SRAM_BYTE_LANES_EN
    mem_en = 1'b1; mem_rw = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 16'hC3C3;
    mem_be = 2'b10;
    observe(7);
    check("be_ub_low",   ub_low, 4);
    check("be_lb_low",   lb_low, 0);
    check("be_rdy_edge", rdy_first, 5);
    gap();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ap_sram_16.md
AP_SRAM_16 -- requirements
Module: ap_sram_16

Interface
REQ-001 SHALL have parameter ADDR_W, default 18; SRAM halfword address width.
REQ-002 SHALL have parameter RD_WAIT, default 2; cycles OE_N held low before read capture, legal range 1..15.
REQ-003 SHALL have parameter WR_WAIT, default 2; cycles WE_N held low per write, legal range 1..15.
REQ-004 SHALL have iCLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have iRESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have iMEM_EN  in  1  request; held high until oMEM_RDY seen.
REQ-007 SHALL have iMEM_RW  in  1  1 = write, 0 = read.
REQ-008 SHALL have iMEM_ADDR  in  32  halfword address; bits above ADDR_W-1 ignored.
REQ-009 SHALL have iMEM_WDATA  in  16  write data.
REQ-010 SHALL have oMEM_RDATA  out  16  read data, registered.
REQ-011 SHALL have oMEM_RDY  out  1  request complete.
REQ-012 SHALL have oSRAM_A  out  ADDR_W  SRAM address.
REQ-013 SHALL have oSRAM_D, oSRAM_D_OE, iSRAM_D  out/out/in  16/1/16  split data bus; pad tristate is outside the block.
REQ-014 SHALL have oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_LB_N, oSRAM_UB_N  out  1 each  active-low strobes, all registered.

Function
REQ-015 SHALL implement FSM states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-016 SHALL, in IDLE with iMEM_EN=1, latch ADDR/RW/WDATA, drive CE_N=0, and go to RD (read) or WR_SETUP (write).
REQ-017 SHALL ignore changes on iMEM_RW/ADDR/WDATA after latching, until DONE exits.
REQ-018 SHALL, in RD, hold OE_N=0 for RD_WAIT cycles; on the last cycle capture iSRAM_D into oMEM_RDATA, then go to DONE.
REQ-019 SHALL spend exactly 1 cycle in WR_SETUP with D_OE=1, WE_N=1, address and data stable.
REQ-020 SHALL hold WE_N=0 for WR_WAIT cycles in WR_PULSE.
REQ-021 SHALL spend 1 cycle in WR_HOLD with WE_N=1 and D_OE=1, then go to DONE.
REQ-022 SHALL never assert OE_N=0 and D_OE=1 in the same cycle.
REQ-023 SHALL set oMEM_RDY=1 in DONE; read RDY rises RD_WAIT+1 edges, write RDY rises WR_WAIT+3 edges, after the edge sampling iMEM_EN in IDLE.
REQ-024 SHALL hold oMEM_RDY and oMEM_RDATA in DONE while iMEM_EN=1, and return to IDLE with RDY=0 on the first edge with iMEM_EN=0.
REQ-025 SHALL require iMEM_EN low for at least 1 cycle between requests; back-to-back starts without a low cycle are not accepted.
REQ-026 SHALL complete an in-flight access if iMEM_EN drops early, then return to IDLE without asserting oMEM_RDY.
REQ-027 SHALL use a 4-bit wait counter that never wraps; it loads on state entry.

Reset
REQ-028 SHALL, on iRESET, force IDLE and set CE_N/OE_N/WE_N/LB_N/UB_N=1, D_OE=0, oMEM_RDY=0, oMEM_RDATA=0, oSRAM_A=0, oSRAM_D=0.
REQ-029 SHALL, on reset mid-write, deassert WE_N on the next edge; the partial write is not retried.

Configuration
REQ-030 SHALL, with AP_SRAM_BYTE_LANES_EN defined, add port iMEM_BE[1:0]; it is latched with the request; BE[0] drives LB_N, BE[1] drives UB_N during the access.
REQ-031 SHALL, without AP_SRAM_BYTE_LANES_EN, omit iMEM_BE and drive LB_N=UB_N=0 during any access.

Structure
REQ-032 SHALL place the FSM state enum and the wait-counter width constant in shared package ap_sram_pkg.
REQ-033 SHALL be a single module with no sub-module.

Verification
REQ-034 SHALL cover: reset, then RD_WAIT=2 read of addr 0x00010 with SRAM returning 0xBEEF -> RDY high 3 edges after EN, RDATA=0xBEEF, OE_N low exactly 2 cycles.
REQ-035 SHALL cover: write 0x1234 to 0x3FFFF, WR_WAIT=2 -> WE_N low exactly 2 cycles, D_OE high 4 cycles, RDY high at edge 5.
REQ-036 SHALL cover: read of 0xFFFC0005 with ADDR_W=18 -> oSRAM_A=0x00005.
REQ-037 SHALL cover: EN held high 10 cycles after RDY, then dropped -> RDY stays 1 and RDATA stable, IDLE 1 edge after drop, next request accepted.
REQ-038 SHALL cover: iRESET during WR_PULSE -> WE_N=1, RDY=0, IDLE on the next edge.
REQ-039 SHALL cover, with AP_SRAM_BYTE_LANES_EN: write with BE=2'b10 -> UB_N=0 and LB_N=1 throughout the access.
